// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser covering all eight octants. It emits one pixel per cycle
// toward the VGA plot port, stalls on plot_ready, and skips off-screen pixels.
module line_draw_engine #(
    parameter int X_WIDTH      = 9,
    parameter int Y_WIDTH      = 8,
    parameter int COLOUR_WIDTH = 3,
    parameter int SCREEN_W     = 320,
    parameter int SCREEN_H     = 240
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    start,
    input  logic [X_WIDTH-1:0]      x0,
    input  logic [Y_WIDTH-1:0]      y0,
    input  logic [X_WIDTH-1:0]      x1,
    input  logic [Y_WIDTH-1:0]      y1,
    input  logic [COLOUR_WIDTH-1:0] colour_in,
    output logic                    ready,
    output logic [X_WIDTH-1:0]      x,
    output logic [Y_WIDTH-1:0]      y,
    output logic [COLOUR_WIDTH-1:0] colour,
    output logic                    plot,
    input  logic                    plot_ready,
    output logic                    done,
    output logic                    clipped
);

    localparam int W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
    localparam logic [X_WIDTH-1:0] X_ONE = X_WIDTH'(1'b1);
    localparam logic [Y_WIDTH-1:0] Y_ONE = Y_WIDTH'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [X_WIDTH-1:0]    r_x1;
    logic [Y_WIDTH-1:0]    r_y1;
    logic signed [W-1:0]   r_dx;
    logic signed [W-1:0]   r_dy;
    logic signed [W-1:0]   r_err;
    logic                  r_sx_neg;
    logic                  r_sy_neg;

    logic signed [W-1:0]   w_x_ext, w_x1_ext, w_y_ext, w_y1_ext;
    logic signed [W-1:0]   w_ddx, w_ddy, w_abs_dx, w_abs_dy;
    logic signed [W:0]     w_e2, w_dx_ext, w_dy_ext;
    logic signed [W-1:0]   w_err_next;
    logic                  w_step_x, w_step_y, w_at_end;
    logic [X_WIDTH-1:0]    w_x_next;
    logic [Y_WIDTH-1:0]    w_y_next;

    function automatic logic on_screen(input logic [X_WIDTH-1:0] px, input logic [Y_WIDTH-1:0] py);
        on_screen = (32'(px) < 32'(SCREEN_W)) && (32'(py) < 32'(SCREEN_H));
    endfunction

    // Setup deltas from the latched endpoints (x,y hold the start point) and the next Bresenham step.
    always_comb begin
        w_x_ext  = $signed({{(W-X_WIDTH){1'b0}}, x});
        w_x1_ext = $signed({{(W-X_WIDTH){1'b0}}, r_x1});
        w_y_ext  = $signed({{(W-Y_WIDTH){1'b0}}, y});
        w_y1_ext = $signed({{(W-Y_WIDTH){1'b0}}, r_y1});
        w_ddx    = w_x1_ext - w_x_ext;
        w_ddy    = w_y1_ext - w_y_ext;
        if (w_ddx[W-1]) begin
            w_abs_dx = -w_ddx;
        end else begin
            w_abs_dx = w_ddx;
        end
        if (w_ddy[W-1]) begin
            w_abs_dy = -w_ddy;
        end else begin
            w_abs_dy = w_ddy;
        end

        w_e2     = {r_err, 1'b0};
        w_dx_ext = {r_dx[W-1], r_dx};
        w_dy_ext = {r_dy[W-1], r_dy};
        w_step_x = (w_e2 >= w_dy_ext);
        w_step_y = (w_e2 <= w_dx_ext);

        // Both corrections are applied to the error term from before this step.
        w_err_next = r_err;
        if (w_step_x) begin
            w_err_next = w_err_next + r_dy;
        end else begin
            w_err_next = w_err_next;
        end
        if (w_step_y) begin
            w_err_next = w_err_next + r_dx;
        end else begin
            w_err_next = w_err_next;
        end

        if (w_step_x) begin
            if (r_sx_neg) begin
                w_x_next = x - X_ONE;
            end else begin
                w_x_next = x + X_ONE;
            end
        end else begin
            w_x_next = x;
        end
        if (w_step_y) begin
            if (r_sy_neg) begin
                w_y_next = y - Y_ONE;
            end else begin
                w_y_next = y + Y_ONE;
            end
        end else begin
            w_y_next = y;
        end

        w_at_end = (x == r_x1) && (y == r_y1);
    end

    // Line FSM; x/y double as the current point so the pixel outputs are registered.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= S_IDLE;
            ready    <= 1'b1;
            plot     <= 1'b0;
            done     <= 1'b0;
            clipped  <= 1'b0;
            x        <= {X_WIDTH{1'b0}};
            y        <= {Y_WIDTH{1'b0}};
            colour   <= {COLOUR_WIDTH{1'b0}};
            r_x1     <= {X_WIDTH{1'b0}};
            r_y1     <= {Y_WIDTH{1'b0}};
            r_dx     <= {W{1'b0}};
            r_dy     <= {W{1'b0}};
            r_err    <= {W{1'b0}};
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        x       <= x0;
                        y       <= y0;
                        r_x1    <= x1;
                        r_y1    <= y1;
                        colour  <= colour_in;
                        clipped <= 1'b0;
                        ready   <= 1'b0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_dx     <= w_abs_dx;
                    r_dy     <= -w_abs_dy;
                    r_err    <= w_abs_dx - w_abs_dy;
                    r_sx_neg <= !(x < r_x1);
                    r_sy_neg <= !(y < r_y1);
                    plot     <= on_screen(x, y);
                    r_state  <= S_DRAW;
                end
                S_DRAW: begin
                    // Off-screen points advance immediately; visible ones wait for the sink.
                    if (!plot || plot_ready) begin
                        if (!plot) begin
                            clipped <= 1'b1;
                        end
                        if (w_at_end) begin
                            plot    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            x     <= w_x_next;
                            y     <= w_y_next;
                            r_err <= w_err_next;
                            plot  <= on_screen(w_x_next, w_y_next);
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    plot    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                    plot    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_draw_engine.sv
// Self-checking bench for line_draw_engine: table vectors, hand sequences and random lines
// compared against a plain-integer Bresenham reference with on-screen filtering.
module tb_line_draw_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] x0, x1;
    logic [7:0] y0, y1;
    logic [2:0] colour_in;
    logic       ready;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       plot_ready;
    logic       done;
    logic       clipped;

    always #5 clk = ~clk;

    line_draw_engine dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .colour_in  (colour_in),
        .ready      (ready),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .plot_ready (plot_ready),
        .done       (done),
        .clipped    (clipped)
    );

    typedef struct {int x; int y;} pt_t;
    typedef struct {
        int x0; int y0; int x1; int y1; int col; int pr_mode;
        int exp_total; int exp_plot; int exp_clip;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    pt_t  exp_q[$];
    pt_t  got_q[$];
    int   model_total;
    int   done_idx, first_idx, stall_cnt;
    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: every point of the line in order, keeping only the visible ones.
    task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1);
        int dx, dy, sx, sy, err, cx, cy, e2;
        exp_q.delete();
        model_total = 0;
        dx  = iabs(ax1 - ax0);
        dy  = -iabs(ay1 - ay0);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        cx  = ax0;
        cy  = ay0;
        for (int i = 0; i < 4096; i++) begin
            model_total++;
            if (cx < 320 && cy < 240) exp_q.push_back('{cx, cy});
            if (cx == ax1 && cy == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; cx += sx; end
            if (e2 <= dx) begin err += dx; cy += sy; end
        end
    endtask

    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1, input int col);
        @(negedge clk);
        chk("ready_before_start", ready, 1);
        x0 = 9'(ax0); y0 = 8'(ay0); x1 = 9'(ax1); y1 = 8'(ay1);
        colour_in = 3'(col);
        start = 1'b1;
    endtask

    // Watches one line from the SETUP cycle (c=0) until done, driving plot_ready per mode.
    task automatic collect(input int col, input int pr_mode, input bit hold,
                           input int bx0, input int by0, input int bx1, input int by1, input int bcol);
        bit have_prev;
        int px, py;
        got_q.delete();
        done_idx  = -1;
        first_idx = -1;
        stall_cnt = 0;
        have_prev = 1'b0;
        px = 0;
        py = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            case (pr_mode)
                0: plot_ready = 1'b1;
                1: plot_ready = ($urandom_range(0, 3) != 0);
                default: plot_ready = ((c % 3) == 0);
            endcase
            if (c == 0) begin
                chk("ready_low_after_accept", ready, 0);
                chk("clipped_cleared", clipped, 0);
                if (hold) begin
                    x0 = 9'(bx0); y0 = 8'(by0); x1 = 9'(bx1); y1 = 8'(by1);
                    colour_in = 3'(bcol);
                end else begin
                    start = 1'b0;
                    x0 = 9'($urandom); y0 = 8'($urandom);
                end
            end
            if (have_prev) begin
                chk("stall_plot_held", plot, 1);
                chk("stall_x_held", x, px);
                chk("stall_y_held", y, py);
            end
            have_prev = 1'b0;
            if (plot) begin
                if (first_idx < 0) first_idx = c;
                if (plot_ready) begin
                    got_q.push_back('{int'(x), int'(y)});
                    chk("pixel_colour", colour, col);
                end else begin
                    have_prev = 1'b1;
                    px = x;
                    py = y;
                    stall_cnt++;
                end
            end
            if (done) begin
                done_idx = c;
                break;
            end
        end
    endtask

    task automatic check_line(input int ax0, input int ay0, input int ax1, input int ay1, input int col,
                              input int pr_mode, input int exp_total, input int exp_plot, input int exp_clip,
                              input bit hold, input int bx0, input int by0, input int bx1, input int by1,
                              input int bcol);
        int n;
        build_model(ax0, ay0, ax1, ay1);
        collect(col, pr_mode, hold, bx0, by0, bx1, by1, bcol);
        if (done_idx < 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("plot_low_at_done", plot, 0);
            chk("clipped_at_done", clipped, exp_clip);
            chk("total_steps", done_idx - 1 - stall_cnt, exp_total);
            if (exp_plot >= 0) chk("plotted_count_const", got_q.size(), exp_plot);
            chk("plotted_count_model", got_q.size(), exp_q.size());
            n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
            for (int i = 0; i < n; i++) begin
                chk("pixel_x", got_q[i].x, exp_q[i].x);
                chk("pixel_y", got_q[i].y, exp_q[i].y);
            end
            if (ax0 < 320 && ay0 < 240) chk("first_pixel_latency", first_idx, 1);
            @(negedge clk);
            chk("done_single_pulse", done, 0);
            chk("ready_after_done", ready, 1);
        end
    endtask

    initial begin
        int sx_exp[8];
        int sy_exp[8];
        int ax0, ay0, ax1, ay1, col;
        bit found;

        sx_exp = '{0, 1, 2, 3, 4, 5, 6, 7};
        sy_exp = '{0, 0, 1, 1, 2, 2, 3, 3};
        //         x0  y0   x1   y1  col pr tot plot clip
        vecs[0] = '{10, 10,   3,  14, 1, 0,  8,  8, 0};
        vecs[1] = '{ 3, 14,  10,  10, 2, 0,  8,  8, 0};
        vecs[2] = '{10, 10,  13,   2, 4, 0,  9,  9, 0};
        vecs[3] = '{13,  2,  10,  10, 6, 0,  9,  9, 0};
        vecs[4] = '{ 0,  0,   4,   4, 7, 2,  5,  5, 0};
        vecs[5] = '{315, 5, 325,   5, 3, 0, 11,  5, 1};
        vecs[6] = '{ 5, 250,  5, 235, 5, 1, 16,  5, 1};
        vecs[7] = '{511, 255, 0,   0, 2, 1, 512, -1, 1};

        reset = 1'b1; start = 1'b0; plot_ready = 1'b0;
        x0 = 9'd0; y0 = 8'd0; x1 = 9'd0; y1 = 8'd0; colour_in = 3'd0;
        repeat (2) @(negedge clk);
        chk("reset_ready", ready, 1);
        chk("reset_plot", plot, 0);
        chk("reset_done", done, 0);
        chk("reset_clipped", clipped, 0);
        chk("reset_x", x, 0);
        chk("reset_y", y, 0);
        chk("reset_colour", colour, 0);
        reset = 1'b0;

        // Shallow line with the exact pixel sequence written out.
        issue(0, 0, 7, 3, 5);
        check_line(0, 0, 7, 3, 5, 0, 8, 8, 0, 1'b0, 0, 0, 0, 0, 0);
        chk("shallow_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            chk("shallow_x", got_q[i].x, sx_exp[i]);
            chk("shallow_y", got_q[i].y, sy_exp[i]);
        end

        foreach (vecs[i]) begin
            issue(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].col);
            check_line(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].col, vecs[i].pr_mode,
                       vecs[i].exp_total, vecs[i].exp_plot, vecs[i].exp_clip, 1'b0, 0, 0, 0, 0, 0);
        end

        // Degenerate line with start held: inputs changed mid-line must not matter,
        // and the second line is taken in the IDLE cycle right after done.
        issue(50, 60, 50, 60, 3);
        check_line(50, 60, 50, 60, 3, 0, 1, 1, 0, 1'b1, 20, 30, 25, 28, 6);
        check_line(20, 30, 25, 28, 6, 0, 6, 6, 0, 1'b0, 0, 0, 0, 0, 0);

        // Start pulsed during DRAW must be ignored.
        issue(30, 40, 36, 40, 1);
        @(negedge clk); start = 1'b0; plot_ready = 1'b1;
        @(negedge clk); start = 1'b1; x0 = 9'd100; y0 = 8'd100; x1 = 9'd101; y1 = 8'd101;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) begin found = 1'b1; break; end
        end
        chk("ignored_start_done", found, 1);
        @(negedge clk);
        chk("ignored_start_idle", ready, 1);
        @(negedge clk);
        chk("ignored_start_not_queued", ready, 1);

        // Reset during the third pixel aborts without a done pulse.
        issue(0, 0, 100, 0, 2);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            plot_ready = 1'b1;
            if (plot && x == 9'd2) begin found = 1'b1; break; end
        end
        chk("reset_reach_pixel3", found, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_plot", plot, 0);
        chk("midreset_ready", ready, 1);
        chk("midreset_done", done, 0);
        chk("midreset_clipped", clipped, 0);
        reset = 1'b0;
        found = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        chk("midreset_no_done", found, 0);
        issue(2, 2, 6, 5, 4);
        check_line(2, 2, 6, 5, 4, 0, 5, 5, 0, 1'b0, 0, 0, 0, 0, 0);

        // Random lines over the full coordinate range with random backpressure.
        for (int r = 0; r < 20; r++) begin
            ax0 = $urandom_range(0, 511);
            ay0 = $urandom_range(0, 255);
            ax1 = $urandom_range(0, 511);
            ay1 = $urandom_range(0, 255);
            col = $urandom_range(0, 7);
            build_model(ax0, ay0, ax1, ay1);
            issue(ax0, ay0, ax1, ay1, col);
            check_line(ax0, ay0, ax1, ay1, col, 1, model_total, -1,
                       (model_total != exp_q.size()) ? 1 : 0, 1'b0, 0, 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_draw_engine.md
Name: line_draw_engine

Overview:
- Parametrised Bresenham line rasteriser that replaces the fixed 320x240, single-octant-swap line FSM.
- Accepts two endpoints and a colour through a start/ready handshake.
- Emits one pixel per cycle toward the vga_adapter plot port, all eight octants, with downstream backpressure and on-screen clipping.
- Sits between the UI FSM and the VGA adapter.

Parameters:
- X_WIDTH, 9, bit width of x coordinates.
- Y_WIDTH, 8, bit width of y coordinates.
- COLOUR_WIDTH, 3, colour bus width.
- SCREEN_W, 320, pixels with x >= SCREEN_W are clipped (not plotted).
- SCREEN_H, 240, pixels with y >= SCREEN_H are clipped.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to draw; accepted when start && ready.
- x0  in  X_WIDTH  start-point x, unsigned.
- y0  in  Y_WIDTH  start-point y, unsigned.
- x1  in  X_WIDTH  end-point x.
- y1  in  Y_WIDTH  end-point y.
- colour_in  in  COLOUR_WIDTH  line colour.
- ready  out  1  high only in IDLE.
- x  out  X_WIDTH  pixel x (registered).
- y  out  Y_WIDTH  pixel y (registered).
- colour  out  COLOUR_WIDTH  pixel colour (registered).
- plot  out  1  pixel valid.
- plot_ready  in  1  downstream accepts the pixel this cycle.
- done  out  1  one-cycle pulse after the last pixel is accepted or skipped.
- clipped  out  1  sticky; set if any pixel of the current line was clipped, cleared on the next accepted start.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is synchronous and active-high.
- Reset values: state=IDLE, ready=1, plot=0, done=0, clipped=0, x=0, y=0, colour=0.
- Reset mid-line aborts the line immediately. No done pulse is issued.
- States: IDLE -> SETUP -> DRAW -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - On start, latch x0, y0, x1, y1 and colour_in, clear clipped, go to SETUP.
  - Input changes after acceptance have no effect.
- SETUP (1 cycle), with W = max(X_WIDTH, Y_WIDTH) + 2 signed bits:
  - dx = |x1-x0|, dy = -|y1-y0|.
  - sx = +1 if x0 < x1, else -1.
  - sy = +1 if y0 < y1, else -1.
  - err = dx + dy.
  - Current point (cx, cy) = (x0, y0).
- DRAW, per step:
  - Present (cx, cy).
  - If on-screen (cx < SCREEN_W and cy < SCREEN_H): drive plot=1 and hold x, y and colour stable until plot_ready=1 at a rising edge, then advance.
  - If off-screen: plot=0, set clipped, advance the same cycle without waiting for plot_ready.
  - Advance step: if (cx, cy) == (x1, y1), go to DONE. Otherwise compute e2 = 2*err:
    - if e2 >= dy: err += dy, cx += sx.
    - if e2 <= dx: err += dx, cy += sy.
    - Both updates use the pre-update err.
- Throughput: one pixel per cycle while plot_ready=1.
- Latency: start accepted at edge N, first pixel has plot=1 at cycle N+2.
- Pixel count per line = max(dx, |dy|) + 1, exactly. Both endpoints are included and no pixel is repeated.
- Degenerate x0=x1 and y0=y1: exactly one pixel, then done.
- DONE: done=1 for one cycle, plot=0, then IDLE.
  - ready rises the cycle after done.
  - A back-to-back start is accepted in that IDLE cycle.
- start while not in IDLE is ignored and not queued.
- Arithmetic: all deltas and err are computed in W-bit two's complement, so there is no overflow at the maximum coordinates for any parameter set.
- plot_ready low while plot=0 has no effect.

Test Plan:
- Shallow line: reset, start (0,0)->(7,3) colour 3'b101, plot_ready=1 -> 8 pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2),(6,3),(7,3) on consecutive cycles, first pixel at cycle N+2; done pulses once; colour=101 on every pixel.
- All octants: endpoints (10,10)->(3,14) and (10,10)->(13,2) plus the reversed pairs -> pixel sets match a reference Bresenham model; counts 8 and 9; first pixel = x0,y0 and last = x1,y1.
- Backpressure: line (0,0)->(4,4) with plot_ready toggling 1,0,0,1,… -> exactly 5 pixels accepted, x/y stable while stalled, no pixel dropped or duplicated.
- Clipping: (315,5)->(325,5) with SCREEN_W=320 -> 5 pixels x=315..319 plotted, 6 cycles with plot=0, clipped=1, done after x=325 step.
- Degenerate and back-to-back: (50,60)->(50,60) -> one pixel then done; start held high -> second line accepted in the IDLE cycle after done; start asserted during DRAW ignored.
- Reset mid-line: assert reset during pixel 3 of (0,0)->(100,0) -> next cycle plot=0, ready=1, no done, clipped=0; a new start draws normally.
